// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, direction indices, receiver states and key lookup for the PS/2 key decoder
package ps2_pkg;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_SHOOT = 8'h29;
    localparam logic [7:0] SC_P2_UP    = 8'h1D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P2_RIGHT = 8'h23;
    localparam logic [7:0] SC_P2_SHOOT = 8'h2B;

    localparam int DIR_DOWN  = 0;
    localparam int DIR_UP    = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // held-key vector layout: [3:0] p1 dirs, [4] p1 shoot, [8:5] p2 dirs, [9] p2 shoot
    localparam int K_P1_SHOOT = 4;
    localparam int K_P2_BASE  = 5;
    localparam int K_P2_SHOOT = 9;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_state_t;

    function automatic logic [9:0] key_mask(input logic ext, input logic [7:0] code);
        logic [9:0] m;
        m = '0;
        case ({ext, code})
            {1'b1, SC_P1_UP}:    m[DIR_UP] = 1'b1;
            {1'b1, SC_P1_DOWN}:  m[DIR_DOWN] = 1'b1;
            {1'b1, SC_P1_LEFT}:  m[DIR_LEFT] = 1'b1;
            {1'b1, SC_P1_RIGHT}: m[DIR_RIGHT] = 1'b1;
            {1'b0, SC_P1_SHOOT}: m[K_P1_SHOOT] = 1'b1;
            {1'b0, SC_P2_UP}:    m[K_P2_BASE + DIR_UP] = 1'b1;
            {1'b0, SC_P2_DOWN}:  m[K_P2_BASE + DIR_DOWN] = 1'b1;
            {1'b0, SC_P2_LEFT}:  m[K_P2_BASE + DIR_LEFT] = 1'b1;
            {1'b0, SC_P2_RIGHT}: m[K_P2_BASE + DIR_RIGHT] = 1'b1;
            {1'b0, SC_P2_SHOOT}: m[K_P2_SHOOT] = 1'b1;
            default:             m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] dir_prio(input logic [3:0] d);
        return d[DIR_UP]    ? 4'b0010 :
               d[DIR_DOWN]  ? 4'b0001 :
               d[DIR_LEFT]  ? 4'b0100 :
               d[DIR_RIGHT] ? 4'b1000 : 4'b0000;
    endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 pin synchronizer, frame receiver FSM and inter-edge timeout
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, fall, din;
    rx_state_t     state;
    logic [3:0]    bit_cnt;
    logic [8:0]    sr;
    logic [TW-1:0] to_cnt;

    assign fall = !clk_sync[1] && clk_prev;
    assign din  = data_sync[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync      <= 2'b11;
            data_sync     <= 2'b11;
            clk_prev      <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= '0;
            sr            <= '0;
            to_cnt        <= '0;
            byte_o        <= '0;
            byte_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clk_i};
            data_sync     <= {data_sync[0], ps2_data_i};
            clk_prev      <= clk_sync[1];
            byte_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
            to_cnt        <= (fall || state != SHIFT) ? '0 : to_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (fall) begin
                        if (!din) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end else begin
                            frame_error_o <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        // sr holds data LSB-first in [7:0] and parity in [8] by the stop edge
                        if (bit_cnt == 4'd9) begin
                            if (din && ^sr) begin
                                state  <= DONE;
                                byte_o <= sr[7:0];
                            end else begin
                                state         <= IDLE;
                                frame_error_o <= 1'b1;
                            end
                        end else begin
                            sr      <= {din, sr[8:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state         <= IDLE;
                        frame_error_o <= 1'b1;
                    end
                end
                DONE: begin
                    byte_valid_o <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scan codes into held-key levels for the two tank players
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic       frame_error_o
);
    logic [7:0] rx_byte;
    logic       rx_valid, ext, brk, is_key;
    logic [9:0] held, held_next, mask;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_error_o(frame_error_o)
    );

    assign mask      = key_mask(ext, rx_byte);
    assign is_key    = rx_valid && rx_byte != SC_EXT && rx_byte != SC_BRK;
    assign held_next = !is_key ? held : brk ? held & ~mask : held | mask;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ext              <= 1'b0;
            brk              <= 1'b0;
            held             <= '0;
            player_1_move_o  <= '0;
            player_2_move_o  <= '0;
            player_1_shoot_o <= 1'b0;
            player_2_shoot_o <= 1'b0;
        end else begin
            // prefixes accumulate until any key code, mapped or not, consumes them
            ext              <= (rx_valid && rx_byte == SC_EXT) ? 1'b1 : is_key ? 1'b0 : ext;
            brk              <= (rx_valid && rx_byte == SC_BRK) ? 1'b1 : is_key ? 1'b0 : brk;
            held             <= held_next;
            player_1_move_o  <= dir_prio(held_next[3:0]);
            player_2_move_o  <= dir_prio(held_next[K_P2_BASE +: 4]);
            player_1_shoot_o <= held_next[K_P1_SHOOT];
            player_2_shoot_o <= held_next[K_P2_SHOOT];
        end
    end
endmodule
